// File: rtl/ahb_ram_arbiter.sv
// ahb_ram_arbiter: two-master AHB grant/ownership control for the shared on-chip RAM.
// Re-arbitrates only on hready boundaries, outside fixed bursts and locked sequences.
module ahb_ram_arbiter #(
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned ROUND_ROBIN    = 1
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] hbusreq,
  input  logic [1:0] hlock,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hready,
  output logic [1:0] hgrant,
  output logic       hmaster,
  output logic       hmaster_d,
  output logic       hmastlock
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  localparam logic       DEF_IDX   = (DEFAULT_MASTER != 0);
  localparam logic       RR_EN     = (ROUND_ROBIN != 0);
  localparam logic [1:0] DEF_GRANT = DEF_IDX ? 2'b10 : 2'b01;

  htrans_e    trans;
  logic [3:0] burst_last;
  logic [3:0] beats_q, beats_d;
  logic [1:0] hgrant_q, hgrant_d;
  logic       hmaster_q, hmaster_d_q, hmastlock_q;
  logic       rr_q, rr_d;
  logic       grant_idx, owner_locked, arb_ok, winner;

  always_comb trans = htrans_e'(htrans);

  always_comb begin
    burst_last = '0;
    case (hburst)
      3'b010, 3'b011: burst_last = 4'd3;
      3'b100, 3'b101: burst_last = 4'd7;
      3'b110, 3'b111: burst_last = 4'd15;
      default:        burst_last = '0;
    endcase
  end

  always_comb begin
    beats_d = beats_q;
    if (hready) begin
      case (trans)
        TR_IDLE:   beats_d = '0;
        TR_BUSY:   beats_d = beats_q;
        TR_NONSEQ: beats_d = burst_last;
        TR_SEQ:    beats_d = (beats_q != '0) ? beats_q - 4'd1 : '0;
        default:   beats_d = beats_q;
      endcase
    end
  end

  always_comb begin
    grant_idx    = hgrant_q[1];
    owner_locked = hlock[hmaster_q] & hbusreq[hmaster_q];
    arb_ok       = hready && (beats_d == '0) && (grant_idx == hmaster_q) && !owner_locked;
  end

  // rr_q names the master preferred at the next contended decision; every
  // contended decision hands that preference to the master that lost it.
  always_comb begin
    winner = DEF_IDX;
    case (hbusreq)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = RR_EN ? rr_q : 1'b0;
      default: winner = DEF_IDX;
    endcase
    rr_d = rr_q;
    if (RR_EN && arb_ok && (hbusreq == 2'b11)) rr_d = ~winner;
    hgrant_d = hgrant_q;
    if (arb_ok) hgrant_d = winner ? 2'b10 : 2'b01;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      beats_q     <= '0;
      hgrant_q    <= DEF_GRANT;
      hmaster_q   <= DEF_IDX;
      hmaster_d_q <= DEF_IDX;
      hmastlock_q <= 1'b0;
      rr_q        <= 1'b0;
    end else begin
      beats_q  <= beats_d;
      hgrant_q <= hgrant_d;
      rr_q     <= rr_d;
      if (hready) begin
        hmaster_q   <= grant_idx;
        hmaster_d_q <= hmaster_q;
        hmastlock_q <= hlock[grant_idx];
      end
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmaster_d = hmaster_d_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Directed bench for ahb_ram_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_ahb_ram_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_WRAP16 = 3'b110;

  logic       HCLK, HRESETn;
  logic [1:0] hbusreq, hlock, htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hgrant, hgrant_fx;
  logic       hmaster, hmaster_d, hmastlock;
  logic       hmaster_fx, hmaster_d_fx, hmastlock_fx;

  int errors = 0;
  int checks = 0;

  ahb_ram_arbiter #(.DEFAULT_MASTER(0), .ROUND_ROBIN(1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant), .hmaster(hmaster), .hmaster_d(hmaster_d), .hmastlock(hmastlock)
  );

  ahb_ram_arbiter #(.DEFAULT_MASTER(0), .ROUND_ROBIN(0)) dut_fx (
    .HCLK(HCLK), .HRESETn(HRESETn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant_fx), .hmaster(hmaster_fx), .hmaster_d(hmaster_d_fx), .hmastlock(hmastlock_fx)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] lck, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy);
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    drive(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    repeat (3) tick();
    checks++;
    if ({hgrant, hmaster, hmaster_d, hmastlock} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_rr: got g=%b m=%b md=%b lk=%b expected g=01 m=0 md=0 lk=0",
               hgrant, hmaster, hmaster_d, hmastlock);
    end
    checks++;
    if ({hgrant_fx, hmaster_fx, hmaster_d_fx, hmastlock_fx} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_fixed: got g=%b m=%b md=%b lk=%b expected g=01 m=0 md=0 lk=0",
               hgrant_fx, hmaster_fx, hmaster_d_fx, hmastlock_fx);
    end
    checks++;
    if (dut.beats_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_beats: got %0d expected 0", dut.beats_q);
    end
    HRESETn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({hgrant, hmaster, hmaster_d, hmastlock} !== 5'b01000) begin
        errors++;
        $display("FAIL idle cycle %0d: got g=%b m=%b md=%b lk=%b expected g=01 m=0 md=0 lk=0",
                 i, hgrant, hmaster, hmaster_d, hmastlock);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g  [7] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    logic       exp_m  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       exp_md [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    drive(2'b11, 2'b00, T_NONSEQ, B_SINGLE, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (hgrant !== exp_g[i]) begin
        errors++;
        $display("FAIL rr_grant edge %0d: got %b expected %b", i, hgrant, exp_g[i]);
      end
      checks++;
      if ({hmaster, hmaster_d} !== {exp_m[i], exp_md[i]}) begin
        errors++;
        $display("FAIL rr_master edge %0d: got m=%b md=%b expected m=%b md=%b",
                 i, hmaster, hmaster_d, exp_m[i], exp_md[i]);
      end
      checks++;
      if (hgrant_fx !== 2'b01) begin
        errors++;
        $display("FAIL fixed_grant edge %0d: got %b expected 01", i, hgrant_fx);
      end
    end
  endtask

  task automatic test_burst_protection();
    logic [3:0] exp_b [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
    logic [1:0] exp_g [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    drive(2'b10, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    tick();
    checks++;
    if ({hgrant, hmaster} !== 3'b101) begin
      errors++;
      $display("FAIL burst_setup: got g=%b m=%b expected g=10 m=1", hgrant, hmaster);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(2'b10, 2'b00, T_NONSEQ, B_INCR4, 1'b1);
      else        drive(2'b11, 2'b00, T_SEQ, B_INCR4, 1'b1);
      tick();
      checks++;
      if (hgrant !== exp_g[i] || dut.beats_q !== exp_b[i]) begin
        errors++;
        $display("FAIL burst beat %0d: got g=%b beats=%0d expected g=%b beats=%0d",
                 i + 1, hgrant, dut.beats_q, exp_g[i], exp_b[i]);
      end
    end
    checks++;
    if (hmaster !== 1'b1) begin
      errors++;
      $display("FAIL burst_last_master: got %b expected 1", hmaster);
    end
    drive(2'b11, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    checks++;
    if ({hgrant, hmaster, hmaster_d} !== 4'b0101) begin
      errors++;
      $display("FAIL burst_handover: got g=%b m=%b md=%b expected g=01 m=0 md=1",
               hgrant, hmaster, hmaster_d);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    drive(2'b11, 2'b00, T_NONSEQ, B_INCR8, 1'b1);
    tick();
    checks++;
    if (hgrant !== 2'b01 || dut.beats_q !== 4'd7) begin
      errors++;
      $display("FAIL wait beat1: got g=%b beats=%0d expected g=01 beats=7", hgrant, dut.beats_q);
    end
    drive(2'b10, 2'b00, T_SEQ, B_INCR8, 1'b1);
    tick();
    checks++;
    if (hgrant !== 2'b01 || dut.beats_q !== 4'd6) begin
      errors++;
      $display("FAIL wait beat2: got g=%b beats=%0d expected g=01 beats=6", hgrant, dut.beats_q);
    end
    drive(2'b10, 2'b00, T_SEQ, B_INCR8, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({hgrant, hmaster, hmaster_d, hmastlock} !== 5'b01000 || dut.beats_q !== 4'd6) begin
        errors++;
        $display("FAIL wait frozen %0d: got g=%b m=%b md=%b lk=%b beats=%0d expected g=01 m=0 md=0 lk=0 beats=6",
                 i, hgrant, hmaster, hmaster_d, hmastlock, dut.beats_q);
      end
    end
    drive(2'b10, 2'b00, T_SEQ, B_INCR8, 1'b1);
    for (int b = 3; b <= 7; b++) begin
      tick();
      checks++;
      if (hgrant !== 2'b01 || dut.beats_q !== 4'(8 - b)) begin
        errors++;
        $display("FAIL wait beat%0d: got g=%b beats=%0d expected g=01 beats=%0d",
                 b, hgrant, dut.beats_q, 8 - b);
      end
    end
    tick();
    checks++;
    if (hgrant !== 2'b10 || hmaster !== 1'b0 || dut.beats_q !== 4'd0) begin
      errors++;
      $display("FAIL wait beat8: got g=%b m=%b beats=%0d expected g=10 m=0 beats=0",
               hgrant, hmaster, dut.beats_q);
    end
    drive(2'b10, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    checks++;
    if ({hmaster, hmaster_d} !== 2'b10) begin
      errors++;
      $display("FAIL wait_handover: got m=%b md=%b expected m=1 md=0", hmaster, hmaster_d);
    end
  endtask

  task automatic test_locked();
    do_reset();
    drive(2'b11, 2'b01, T_NONSEQ, B_SINGLE, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({hgrant, hmaster, hmastlock} !== 4'b0101) begin
        errors++;
        $display("FAIL lock xfer %0d: got g=%b m=%b lk=%b expected g=01 m=0 lk=1",
                 i, hgrant, hmaster, hmastlock);
      end
    end
    drive(2'b10, 2'b00, T_NONSEQ, B_SINGLE, 1'b1);
    tick();
    checks++;
    if (hgrant !== 2'b10 || hmastlock !== 1'b0) begin
      errors++;
      $display("FAIL lock_release: got g=%b lk=%b expected g=10 lk=0", hgrant, hmastlock);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(2'b10, 2'b10, T_IDLE, B_SINGLE, 1'b1);
    tick();
    tick();
    drive(2'b10, 2'b10, T_NONSEQ, B_WRAP16, 1'b1);
    tick();
    drive(2'b10, 2'b10, T_SEQ, B_WRAP16, 1'b1);
    repeat (3) tick();
    checks++;
    if ({hgrant, hmaster, hmaster_d, hmastlock} !== 5'b10111 || dut.beats_q !== 4'd12) begin
      errors++;
      $display("FAIL wrap16 beat4: got g=%b m=%b md=%b lk=%b beats=%0d expected g=10 m=1 md=1 lk=1 beats=12",
               hgrant, hmaster, hmaster_d, hmastlock, dut.beats_q);
    end
    HRESETn = 1'b0;
    tick();
    checks++;
    if ({hgrant, hmaster, hmaster_d, hmastlock} !== 5'b01000 || dut.beats_q !== 4'd0) begin
      errors++;
      $display("FAIL midburst_reset: got g=%b m=%b md=%b lk=%b beats=%0d expected g=01 m=0 md=0 lk=0 beats=0",
               hgrant, hmaster, hmaster_d, hmastlock, dut.beats_q);
    end
    HRESETn = 1'b1;
    drive(2'b10, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    tick();
    drive(2'b10, 2'b00, T_NONSEQ, B_INCR4, 1'b1);
    tick();
    checks++;
    if (hgrant !== 2'b10 || hmaster !== 1'b1 || dut.beats_q !== 4'd3) begin
      errors++;
      $display("FAIL early_term beat1: got g=%b m=%b beats=%0d expected g=10 m=1 beats=3",
               hgrant, hmaster, dut.beats_q);
    end
    drive(2'b01, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    checks++;
    if (hgrant !== 2'b01 || dut.beats_q !== 4'd0) begin
      errors++;
      $display("FAIL early_term idle: got g=%b beats=%0d expected g=01 beats=0", hgrant, dut.beats_q);
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    drive(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    test_reset();
    test_round_robin();
    test_burst_protection();
    test_wait_states();
    test_locked();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
